// File: rtl/riscv_pkg.sv
// +----------------------------------------------------------------------+
// | riscv_pkg : shared encodings for the RV32I multicycle controller     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/main_fsm_if.sv
// +----------------------------------------------------------------------+
// | main_fsm_if : controller <-> datapath control/status bundle          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

interface main_fsm_if;

    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       AdrSrc;
    logic       IRWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOP;
    logic [1:0] ResultSrc;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       illegal;

    modport master (
        input  op, zero, mem_ready,
        output AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOP, ResultSrc,
        output PCWrite, RegWrite, MemWrite, illegal
    );

    modport slave (
        output op, zero, mem_ready,
        input  AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOP, ResultSrc,
        input  PCWrite, RegWrite, MemWrite, illegal
    );

endinterface

`default_nettype wire

// File: rtl/main_fsm.sv
// +----------------------------------------------------------------------+
// | main_fsm : multicycle RV32I control FSM (lw/sw/R/I/beq/jal)          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module main_fsm
    import riscv_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    main_fsm_if.master  bus
);

    state_t state_q;
    state_t state_d;
    state_t w_dec_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
            MEMWRITE: if (bus.mem_ready) state_d = FETCH;
            MEMWB:    state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Under reset the selects present FETCH values; enables are cleared below.
    assign w_dec_state = rst ? FETCH : state_q;

    always_comb begin
        bus.AdrSrc    = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RS2;
        bus.ALUOP     = ALUOP_ADD;
        bus.ResultSrc = RES_ALUOUT;
        bus.PCWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.illegal   = 1'b0;
        case (w_dec_state)
            FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                bus.IRWrite   = bus.mem_ready & ~rst;
                bus.PCWrite   = bus.mem_ready & ~rst;
            end
            DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: bus.illegal = 1'b0;
                    default:                                  bus.illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = bus.mem_ready;
            end
            MEMWB: begin
                bus.ResultSrc = RES_MEMDATA;
                bus.RegWrite  = 1'b1;
            end
            EXECUTER: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUOP   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOP   = ALUOP_FUNCT;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
            end
            BEQ: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUOP   = ALUOP_SUB;
                bus.PCWrite = bus.zero;
            end
            JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCWrite = 1'b1;
            end
            default: begin
                bus.AdrSrc = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire
